// File: rtl/pipe_register_if.sv
// Handshake bundle for pipe_register: input word plus stall/flush controls,
// with the last-stage word and occupancy count coming back.
interface pipe_register_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, stall, flush,
        input  out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, stall, flush,
        output out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_register.sv
// DEPTH-stage data+valid delay line with stall (hold), flush (bubble insert)
// and a registered count of stages currently holding a valid word.
module pipe_register #(
    parameter int               WIDTH     = 64,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic            clk,
    input logic            reset,
    pipe_register_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_depth_chk
        $error("pipe_register: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_width_chk
        $error("pipe_register: WIDTH must be at least 1");
    end
    if ($bits(bus.in_data) != WIDTH) begin : g_bus_chk
        $error("pipe_register: interface WIDTH does not match module WIDTH");
    end

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    count_q;

    // Reset and flush both leave the pipe full of invalid RESET_VAL bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else if (!bus.stall) begin
            data_q[0]  <= bus.in_data;
            valid_q[0] <= bus.in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
            // Entering and leaving words can coincide; modular arithmetic nets them out.
            count_q <= count_q + CW'(bus.in_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register: DEPTH=3 (RESET_VAL=0) and DEPTH=1
// (RESET_VAL=64'hD503201F) instances driven with hand-computed vectors.
module tb_pipe_register;
    logic clk;
    logic reset;

    pipe_register_if #(.WIDTH(64), .DEPTH(3)) bus3 ();
    pipe_register_if #(.WIDTH(64), .DEPTH(1)) bus1 ();

    pipe_register #(.WIDTH(64), .DEPTH(3), .RESET_VAL(64'h0)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    pipe_register #(.WIDTH(64), .DEPTH(1), .RESET_VAL(64'hD503201F)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic        v;
        logic [63:0] d;
        logic [63:0] c;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    localparam logic [63:0] NOP1 = 64'hD503201F;
    localparam logic [63:0] HEXW = 64'h3456789ABCDEF012;
    localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_dut(input string name, input int sel, input logic v,
                             input logic [63:0] d, input logic [63:0] c);
        if (sel == 3) begin
            check({name, ".valid"}, {63'd0, bus3.out_valid}, {63'd0, v});
            check({name, ".data"},  bus3.out_data, d);
            check({name, ".count"}, {62'd0, bus3.count}, c);
        end else begin
            check({name, ".valid"}, {63'd0, bus1.out_valid}, {63'd0, v});
            check({name, ".data"},  bus1.out_data, d);
            check({name, ".count"}, {63'd0, bus1.count}, c);
        end
    endtask

    // One clock edge: drive inputs at negedge, queue the outputs expected after the edge.
    task automatic step(input int sel, input logic iv, input logic [63:0] id,
                        input logic st, input logic fl, input string name,
                        input logic ev, input logic [63:0] ed, input int ec);
        exp_t e;
        @(negedge clk);
        if (sel == 3) begin
            bus3.in_valid = iv; bus3.in_data = id; bus3.stall = st; bus3.flush = fl;
        end else begin
            bus1.in_valid = iv; bus1.in_data = id; bus1.stall = st; bus1.flush = fl;
        end
        e.name = name; e.sel = sel; e.v = ev; e.d = ed; e.c = 64'(ec);
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_dut(e.name, e.sel, e.v, e.d, e.c);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus3.in_valid = 0; bus3.in_data = 0; bus3.stall = 0; bus3.flush = 0;
        bus1.in_valid = 0; bus1.in_data = 0; bus1.stall = 0; bus1.flush = 0;
        #12;
        check_dut("init_rst3", 3, 1'b0, 64'd0, 0);
        check_dut("init_rst1", 1, 1'b0, NOP1, 0);
        @(negedge clk);
        reset = 1'b0;

        // fill with three valid words, then keep shifting
        step(3, 1, 64'd527, 0, 0, "fill1", 0, 64'd0, 1);
        step(3, 1, NEG8,    0, 0, "fill2", 0, 64'd0, 2);
        step(3, 1, HEXW,    0, 0, "fill3", 1, 64'd527, 3);
        step(3, 1, 64'd100, 0, 0, "fill4", 1, NEG8, 3);
        step(3, 1, 64'd200, 0, 0, "fill5", 1, HEXW, 3);

        // stall holds everything; 77 is discarded
        step(3, 1, 64'd77,  1, 0, "stall1", 1, HEXW, 3);
        step(3, 1, 64'd77,  1, 0, "stall2", 1, HEXW, 3);
        step(3, 1, 64'd300, 0, 0, "resume1", 1, 64'd100, 3);
        step(3, 1, 64'd400, 0, 0, "resume2", 1, 64'd200, 3);
        step(3, 1, 64'd500, 0, 0, "resume3", 1, 64'd300, 3);

        // flush beats stall, input lost
        step(3, 1, 64'd999, 1, 1, "flush_stall", 0, 64'd0, 0);
        step(3, 0, 64'd0,   0, 0, "post_flush", 0, 64'd0, 0);

        // invalid words still move but are not counted
        step(3, 0, 64'd981, 0, 0, "inv1", 0, 64'd0, 0);
        step(3, 1, 64'd345, 0, 0, "inv2", 0, 64'd0, 1);
        step(3, 0, 64'd0,   0, 0, "inv3", 0, 64'd981, 1);
        step(3, 0, 64'd0,   0, 0, "inv4", 1, 64'd345, 1);
        step(3, 0, 64'd0,   0, 0, "inv5", 0, 64'd0, 0);

        // async reset mid-cycle with a full pipe
        step(3, 1, 64'd11, 0, 0, "refill1", 0, 64'd0, 1);
        step(3, 1, 64'd22, 0, 0, "refill2", 0, 64'd0, 2);
        step(3, 1, 64'd33, 0, 0, "refill3", 1, 64'd11, 3);
        #1;
        reset = 1'b1;
        #1;
        check_dut("async_rst", 3, 1'b0, 64'd0, 0);
        @(posedge clk);
        #1;
        check_dut("rst_held", 3, 1'b0, 64'd0, 0);
        #2;
        reset = 1'b0;
        step(3, 1, 64'd44, 0, 0, "post_rst", 0, 64'd0, 1);

        // DEPTH=1 behaves as a plain register with NOP bubbles
        step(1, 1, 64'd18, 0, 0, "d1_load", 1, 64'd18, 1);
        step(1, 1, 64'd9,  1, 0, "d1_stall", 1, 64'd18, 1);
        step(1, 0, 64'd5,  0, 0, "d1_inv", 0, 64'd5, 0);
        step(1, 1, 64'd6,  0, 0, "d1_load2", 1, 64'd6, 1);
        step(1, 1, 64'd7,  0, 1, "d1_flush", 0, NOP1, 0);

        @(posedge clk);
        #3;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
